// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Imported by imem_port_arbiter and imem_arb_stats.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int DEPTH_BYTES_DEFAULT = 4096;

endpackage

// File: rtl/imem_arb_stats.sv
// Stall-cycle and completed-session counters, both free-running and wrapping.
// Only instantiated when IMEM_ARB_STATS_EN is defined.
module imem_arb_stats
  import imem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        session_done,
  output logic [31:0] stall_cycles,
  output logic [15:0] sessions
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      sessions     <= '0;
    end else begin
      if (stall)
        stall_cycles <= stall_cycles + 32'd1;
      if (session_done)
        sessions <= sessions + 16'd1;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction memory between the fetch stage and a word loader.
// Optional stats outputs are enabled with IMEM_ARB_STATS_EN.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_addr,
  output logic [31:0]      fetch_instr,
  output logic             fetch_stall,
  output logic             pc_reset,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic             ld_last,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             ld_err,
  output logic             load_busy,
  output logic [CNT_W-1:0] ld_count,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      sessions
`endif
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             accept;
  logic             good;
  logic             done;
  logic [32:0]      end_addr;

  logic stall_raw, pcr_raw, ready_raw;
  logic busy_raw, we_raw;
  logic [31:0] wdata_raw;

  assign end_addr = {1'b0, ld_addr} + 33'd3;
  assign good = (ld_addr[1:0] == 2'b00)
             && (end_addr < 33'(DEPTH_BYTES));

  always_comb begin
    state_nxt   = state;
    stall_raw   = 1'b0;
    pcr_raw     = 1'b0;
    ready_raw   = 1'b0;
    busy_raw    = 1'b0;
    we_raw      = 1'b0;
    wdata_raw   = '0;
    accept      = 1'b0;
    done        = 1'b0;
    mem_addr    = fetch_addr;
    fetch_instr = mem_rdata;
    unique case (state)
      RUN: begin
        if (ld_start)
          state_nxt = LOAD;
      end
      LOAD: begin
        stall_raw   = 1'b1;
        ready_raw   = 1'b1;
        busy_raw    = 1'b1;
        mem_addr    = ld_addr;
        wdata_raw   = ld_data;
        fetch_instr = NOP_INSTR;
        accept      = ld_valid;
        we_raw      = ld_valid && good;
        if (ld_valid && ld_last) begin
          done      = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        stall_raw   = 1'b1;
        pcr_raw     = 1'b1;
        fetch_instr = NOP_INSTR;
        state_nxt   = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && ld_start) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (accept) begin
        if (!good)
          err <= 1'b1;
        else if (!(&cnt))
          cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Reset forces every control output low so nothing can write or pulse.
  assign fetch_stall = stall_raw & ~rst;
  assign pc_reset    = pcr_raw & ~rst;
  assign ld_ready    = ready_raw & ~rst;
  assign load_busy   = busy_raw & ~rst;
  assign mem_we      = we_raw & ~rst;
  assign mem_wdata   = rst ? '0 : wdata_raw;
  assign ld_count    = rst ? '0 : cnt;
  assign ld_err      = err & ~rst;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] sess_q;

  imem_arb_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .stall        (fetch_stall),
    .session_done (done & ~rst),
    .stall_cycles (stall_q),
    .sessions     (sess_q)
  );

  assign stall_cycles = rst ? '0 : stall_q;
  assign sessions     = rst ? '0 : sess_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed, table-driven bench for imem_port_arbiter.
// Define IMEM_ARB_STATS_EN to also check the stats counters.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_stall;
  logic        pc_reset;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_last;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_err;
  logic        load_busy;
  logic [11:0] ld_count;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] sessions;
`endif

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .DEPTH_BYTES (4096),
    .CNT_W       (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_stall (fetch_stall),
    .pc_reset    (pc_reset),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_last     (ld_last),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_err      (ld_err),
    .load_busy   (load_busy),
    .ld_count    (ld_count),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .sessions     (sessions)
`endif
  );

  // Word-organised memory; combinational read, write on clock edge.
  logic [31:0] mem [1024];

  assign mem_rdata = (mem_addr < 32'd4096) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk)
    if (mem_we && mem_addr < 32'd4096)
      mem[mem_addr[11:2]] <= mem_wdata;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, start, valid, last;
    logic [31:0] faddr, addr, data;
    logic        chk_i;
    logic [31:0] instr;
    logic        stall, ready, we, pcr, busy, err;
    logic [11:0] cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic rs, input logic st, input logic vl, input logic la,
    input logic [31:0] fa, input logic [31:0] ad, input logic [31:0] da,
    input logic ci, input logic [31:0] ins,
    input logic sl, input logic rd, input logic we, input logic pr,
    input logic bu, input logic er, input logic [11:0] cn);
    vec_t v;
    v.rst = rs; v.start = st; v.valid = vl; v.last = la;
    v.faddr = fa; v.addr = ad; v.data = da;
    v.chk_i = ci; v.instr = ins;
    v.stall = sl; v.ready = rd; v.we = we; v.pcr = pr;
    v.busy = bu; v.err = er; v.cnt = cn;
    return v;
  endfunction

  localparam logic [31:0] INIT = 32'h00221821;
  localparam logic [31:0] A0 = 32'h11110000;
  localparam logic [31:0] A4 = 32'h22220004;
  localparam logic [31:0] A8 = 32'h33330008;
  localparam logic [31:0] WB = 32'h44440ffc;
  localparam logic [31:0] WC = 32'h5555000c;
  localparam logic [31:0] WD = 32'h66660000;
  localparam logic [31:0] WE = 32'h77770004;
  localparam logic [31:0] WF = 32'h88880008;

  vec_t vt [25];

  task automatic drive(input vec_t v);
    rst        = v.rst;
    ld_start   = v.start;
    ld_valid   = v.valid;
    ld_last    = v.last;
    fetch_addr = v.faddr;
    ld_addr    = v.addr;
    ld_data    = v.data;
  endtask

  int stall_seen, pcr_seen, we_seen;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2] = INIT;

    //      rs st vl la faddr  addr   data ci instr sl rd we pr bu er cnt
    vt[0]  = mk(0,0,0,0, 8, 0,    0,  1, INIT, 0,0,0,0,0,0, 0);
    vt[1]  = mk(0,1,0,0, 8, 0,    0,  1, INIT, 0,0,0,0,0,0, 0);
    vt[2]  = mk(0,0,0,0, 8, 0,    0,  1, 0,    1,1,0,0,1,0, 0);
    vt[3]  = mk(0,0,1,0, 8, 0,    A0, 1, 0,    1,1,1,0,1,0, 0);
    vt[4]  = mk(0,0,1,0, 8, 4,    A4, 1, 0,    1,1,1,0,1,0, 1);
    vt[5]  = mk(0,0,1,1, 8, 8,    A8, 1, 0,    1,1,1,0,1,0, 2);
    vt[6]  = mk(0,0,1,0, 8, 12,   WF, 1, 0,    1,0,0,1,0,0, 3);
    vt[7]  = mk(0,0,1,0, 8, 12,   WF, 1, A8,   0,0,0,0,0,0, 3);
    vt[8]  = mk(0,1,0,0, 8, 0,    0,  1, A8,   0,0,0,0,0,0, 3);
    vt[9]  = mk(0,0,1,0, 8, 6,    WF, 1, 0,    1,1,0,0,1,0, 0);
    vt[10] = mk(0,0,1,0, 8, 4096, WF, 1, 0,    1,1,0,0,1,1, 0);
    vt[11] = mk(0,0,1,0, 8, 4092, WB, 1, 0,    1,1,1,0,1,1, 0);
    vt[12] = mk(0,1,0,0, 8, 0,    0,  1, 0,    1,1,0,0,1,1, 1);
    vt[13] = mk(0,0,1,1, 8, 12,   WC, 1, 0,    1,1,1,0,1,1, 1);
    vt[14] = mk(0,1,0,0, 8, 0,    0,  1, 0,    1,0,0,1,0,1, 2);
    vt[15] = mk(0,1,0,0, 8, 0,    0,  1, A8,   0,0,0,0,0,1, 2);
    vt[16] = mk(0,0,0,0, 8, 0,    0,  1, 0,    1,1,0,0,1,0, 0);
    vt[17] = mk(0,0,1,0, 8, 0,    WD, 1, 0,    1,1,1,0,1,0, 0);
    vt[18] = mk(0,0,1,0, 8, 4,    WE, 1, 0,    1,1,1,0,1,0, 1);
    vt[19] = mk(1,0,1,1, 8, 8,    WF, 0, 0,    0,0,0,0,0,0, 0);
    vt[20] = mk(0,0,0,0, 0, 0,    0,  1, WD,   0,0,0,0,0,0, 0);
    vt[21] = mk(0,0,0,0, 4, 0,    0,  1, WE,   0,0,0,0,0,0, 0);
    vt[22] = mk(0,0,0,0, 4092, 0, 0,  1, WB,   0,0,0,0,0,0, 0);
    vt[23] = mk(0,0,0,0, 12, 0,   0,  1, WC,   0,0,0,0,0,0, 0);
    vt[24] = mk(0,0,0,0, 8, 0,    0,  1, A8,   0,0,0,0,0,0, 0);

    // Reset with loader inputs active: control outputs must stay low.
    rst = 1'b1; ld_start = 1'b1; ld_valid = 1'b1; ld_last = 1'b1;
    fetch_addr = 32'd8; ld_addr = 32'd0; ld_data = 32'hdeadbeef;
    #1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
      chk("rst_we",    {31'd0, mem_we},      32'd0);
      chk("rst_ready", {31'd0, ld_ready},    32'd0);
      chk("rst_busy",  {31'd0, load_busy},   32'd0);
      chk("rst_pcr",   {31'd0, pc_reset},    32'd0);
      chk("rst_cnt",   {20'd0, ld_count},    32'd0);
    end

    for (int i = 0; i < 25; i++) begin
      drive(vt[i]);
      #1;
      if (vt[i].chk_i)
        chk($sformatf("v%0d_instr", i), fetch_instr, vt[i].instr);
      chk($sformatf("v%0d_stall", i), {31'd0, fetch_stall}, {31'd0, vt[i].stall});
      chk($sformatf("v%0d_ready", i), {31'd0, ld_ready},    {31'd0, vt[i].ready});
      chk($sformatf("v%0d_we", i),    {31'd0, mem_we},      {31'd0, vt[i].we});
      chk($sformatf("v%0d_pcr", i),   {31'd0, pc_reset},    {31'd0, vt[i].pcr});
      chk($sformatf("v%0d_busy", i),  {31'd0, load_busy},   {31'd0, vt[i].busy});
      chk($sformatf("v%0d_err", i),   {31'd0, ld_err},      {31'd0, vt[i].err});
      chk($sformatf("v%0d_cnt", i),   {20'd0, ld_count},    {20'd0, vt[i].cnt});
      @(posedge clk); #1;
    end

    // Four-word session with one idle LOAD cycle; count pulses by sampling.
    stall_seen = 0; pcr_seen = 0; we_seen = 0;
    rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; fetch_addr = 32'd16;
    ld_start = 1'b1;
    #1;
    @(posedge clk); #1;
    ld_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ld_valid = (c >= 1 && c <= 4);
      ld_last  = (c == 4);
      ld_addr  = 32'd16 + 32'(4 * (c - 1));
      ld_data  = 32'ha0000000 + 32'(c);
      #1;
      stall_seen += int'(fetch_stall);
      pcr_seen   += int'(pc_reset);
      we_seen    += int'(mem_we);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    chk("s4_stall_count", 32'(stall_seen), 32'd6);
    chk("s4_pcr_count",   32'(pcr_seen),   32'd1);
    chk("s4_we_count",    32'(we_seen),    32'd4);
    chk("s4_cnt",         {20'd0, ld_count}, 32'd4);
    chk("s4_run_stall",   {31'd0, fetch_stall}, 32'd0);
    chk("s4_instr16",     fetch_instr, 32'ha0000001);
    fetch_addr = 32'd28;
    #1;
    chk("s4_instr28",     fetch_instr, 32'ha0000004);
`ifdef IMEM_ARB_STATS_EN
    chk("stats_sessions", {16'd0, sessions}, 32'd1);
    chk("stats_stall",    stall_cycles,      32'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
